jump_unit: RTL
==============

// Module: jump_unit
// PURPOSE
//  Program-counter / branch resolver for the CPU datapath. Consumes the ALU result
//  X plus the instruction's lt/eq/gt condition flags. Either advances the PC, loads
//  a jump target, or halts. Signals a one-cycle pipeline flush after a taken jump.
// PARAMETERS
//  BUS_WIDTH   8  width of ALU result X (two's complement)
//  ADDR_WIDTH  8  width of PC and jump target
//  RESET_ADDR  0  PC value after reset
// PORTS
//  clk       in   1           single clock; all state updates on posedge
//  rst       in   1           synchronous, active-high reset
//  X         in   BUS_WIDTH   ALU result being tested (signed)
//  lt        in   1           jump if X<0
//  eq        in   1           jump if X==0
//  gt        in   1           jump if X>0
//  jump      in   1           current instruction is a conditional jump
//  target    in   ADDR_WIDTH  jump destination
//  valid     in   1           instruction inputs valid this cycle
//  stall     in   1           hold everything this cycle
//  halt_req  in   1           stop execution
//  pc        out  ADDR_WIDTH  current program counter (registered)
//  taken     out  1           1-cycle pulse: jump was taken
//  flush     out  1           high while in FLUSH state
//  halted    out  1           high in HALTED state
// BEHAVIOUR
//  Reset:
//   - pc=RESET_ADDR, taken=0, flush=0, halted=0, state=RUN.
//   - Reset overrides all other inputs in any state, including FLUSH and HALTED.
//  Condition (combinational, same cycle):
//   - neg = X[MSB]; zero = (X==0); pos = ~neg & ~zero.
//   - cond = (lt&eq&gt) | (lt&neg) | (eq&zero) | (gt&pos).
//   - lt=eq=gt=0 never jumps; lt=eq=gt=1 always jumps.
//  States: RUN, FLUSH, HALTED. All outputs are registered.
//  RUN, stall=1:
//   - pc holds, no transition, taken=0; halt_req is ignored.
//  RUN, stall=0, priority highest first:
//   1. halt_req -> HALTED; pc holds.
//   2. valid & jump & cond -> pc<=target, taken=1 next cycle, enter FLUSH.
//   3. valid -> pc<=pc+1, modulo 2^ADDR_WIDTH (0xFF+1=0x00 at width 8).
//   4. else pc holds.
//  FLUSH (exactly one non-stalled cycle):
//   - flush=1; valid, jump and halt_req are ignored; pc holds.
//   - Returns to RUN when stall=0; stall=1 extends FLUSH.
//  HALTED:
//   - halted=1; pc frozen; all inputs ignored; only rst exits.
//  Outputs:
//   - taken is high only in the cycle after the taken decision, never 2 cycles running.
//   - target is used verbatim; there is no relative addressing.
//  Latency: decision on cycle N is visible on pc/taken/flush at cycle N+1.
// STRUCTURE
//  Shared package/header:
//   - state encodings ST_RUN=2'd0, ST_FLUSH=2'd1, ST_HALTED=2'd2.
//   - 2'd3 is illegal and recovers to ST_RUN.
//  Sub-module jump_condition:
//   - params BUS_WIDTH; ports X, lt, eq, gt -> cond; purely combinational.
//  Top: state register, pc register, next-state/next-pc logic.
// TESTING (BUS_WIDTH=8, ADDR_WIDTH=8, RESET_ADDR=0)
//  1. Reset, valid=1, jump=0 for 3 cycles -> pc 0,1,2,3; taken=flush=halted=0.
//  2. pc=0xFF, valid=1 -> pc=0x00.
//  3. Jump on zero:
//     - jump=1, eq=1, X=0x00, target=0x40 -> pc=0x40, taken=1, flush=1 next cycle.
//     - Following valid jump is ignored; pc stays 0x40, then increments to 0x41.
//  4. Sign checks, all with jump=1, lt=1:
//     - X=0x05 -> not taken, pc+1.
//     - X=0x80 -> taken.
//     - gt=1, X=0x00 -> not taken.
//  5. Flag extremes:
//     - lt=eq=gt=1, X=0x12 -> taken.
//     - lt=eq=gt=0, X=0x00 -> not taken, pc+1.
//  6. Halt and reset:
//     - halt_req with stall=1 -> ignored.
//     - Then stall=0 -> halted=1, pc frozen despite valid.
//     - rst during FLUSH -> pc=0, flush=0.

Source files
------------

// File: rtl/jump_unit_pkg.sv
// Shared definitions for the program-counter / branch resolver.
package jump_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_HALTED  = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

endpackage

// File: rtl/jump_unit_condition.sv
// Combinational branch condition: compares the sign/zero class of X against the
// instruction's lt/eq/gt flags.
module jump_condition
  import jump_unit_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic signed [BUS_WIDTH-1:0] X,
  input  logic                        lt,
  input  logic                        eq,
  input  logic                        gt,
  output logic                        cond
);

  logic w_neg;
  logic w_zero;
  logic w_pos;

  assign w_neg  = X[BUS_WIDTH-1];
  assign w_zero = (X == '0);
  assign w_pos  = ~w_neg & ~w_zero;

  // All three flags set is an unconditional jump regardless of X.
  assign cond = (lt & eq & gt) | (lt & w_neg) | (eq & w_zero) | (gt & w_pos);

endmodule

// File: rtl/jump_unit.sv
// Program counter and branch resolver: advances, jumps (with a one-cycle
// flush) or halts. All outputs come straight from registers.
module jump_unit
  import jump_unit_pkg::*;
#(
  parameter int                    BUS_WIDTH  = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [BUS_WIDTH-1:0]  X,
  input  logic                         lt,
  input  logic                         eq,
  input  logic                         gt,
  input  logic                         jump,
  input  logic        [ADDR_WIDTH-1:0] target,
  input  logic                         valid,
  input  logic                         stall,
  input  logic                         halt_req,
  output logic        [ADDR_WIDTH-1:0] pc,
  output logic                         taken,
  output logic                         flush,
  output logic                         halted
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [ADDR_WIDTH-1:0]   w_pc_nxt;
  logic                    r_taken;
  logic                    w_taken_nxt;
  logic                    w_cond;

  jump_condition #(
    .BUS_WIDTH(BUS_WIDTH)
  ) u_cond (
    .X   (X),
    .lt  (lt),
    .eq  (eq),
    .gt  (gt),
    .cond(w_cond)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_taken_nxt = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!stall) begin
          if (halt_req) begin
            w_state_nxt = ST_HALTED;
          end else if (valid && jump && w_cond) begin
            w_pc_nxt    = target;
            w_taken_nxt = 1'b1;
            w_state_nxt = ST_FLUSH;
          end else if (valid) begin
            w_pc_nxt = r_pc + ADDR_WIDTH'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (!stall) w_state_nxt = ST_RUN;
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_ADDR;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_taken <= w_taken_nxt;
    end
  end

  assign pc     = r_pc;
  assign taken  = r_taken;
  assign flush  = (r_state == ST_FLUSH);
  assign halted = (r_state == ST_HALTED);

endmodule
